// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard
//  Brief    : Tracks in-flight register writes behind decode; drives E-stage
//             forward selects, decode stall/flush, E bubble and a stall counter.
//  Revision : 1.0
// ============================================================================
module hazard_scoreboard #(
    parameter int AW       = 4,
    parameter int NRD      = 2,
    parameter int STAGES   = 3,
    parameter int LD_AVAIL = 2,
    parameter int CNTW     = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           issue_valid,
    input  logic                           issue_rw,
    input  logic                           issue_ld,
    input  logic [AW-1:0]                  issue_wa,
    input  logic [NRD*AW-1:0]              ra_d,
    input  logic [NRD-1:0]                 ra_use,
    input  logic                           flush,
    input  logic                           mem_wait,
    output logic                           stall,
    output logic                           flush_d,
    output logic                           bubble_e,
    output logic [NRD*$clog2(STAGES)-1:0]  fwd_sel,
    output logic [CNTW-1:0]                stall_cnt
);

    localparam int SW = $clog2(STAGES);

    logic [STAGES-1:0] slot_v;
    logic [STAGES-1:0] slot_rw;
    logic [STAGES-1:0] slot_ld;
    logic [AW-1:0]     slot_wa [STAGES];
    logic [AW-1:0]     ra_e    [NRD];
    logic [NRD-1:0]    use_e;

    logic load_use;
    logic issue_ok;
    logic late_match;

    // A load in slot j reaches its first forwardable slot too late for decode
    // when j+1 < LD_AVAIL; ALU results are forwardable from slot 1 and never stall.
    always_comb begin
        load_use = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            for (int j = 0; j < STAGES; j++) begin
                if (issue_valid && ra_use[p] && slot_v[j] && slot_rw[j] && slot_ld[j] &&
                    (slot_wa[j] == ra_d[p*AW +: AW]) && (j + 1 < LD_AVAIL))
                    load_use = 1'b1;
            end
        end
    end

    always_comb begin
        stall    = 1'b0;
        flush_d  = 1'b0;
        bubble_e = 1'b0;
        if (mem_wait) begin
            stall = 1'b1;
        end else if (flush) begin
            flush_d  = 1'b1;
            bubble_e = 1'b1;
        end else if (load_use) begin
            stall    = 1'b1;
            bubble_e = 1'b1;
        end
    end

    assign issue_ok = issue_valid & ~stall & ~flush;

    // Youngest forwardable producer wins; late_match flags a youngest match
    // that is not yet forwardable, which the stall logic should have prevented.
    always_comb begin
        logic hit_seen;
        logic sel_done;
        fwd_sel    = '0;
        late_match = 1'b0;
        hit_seen   = 1'b0;
        sel_done   = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            hit_seen = 1'b0;
            sel_done = 1'b0;
            for (int k = 1; k < STAGES; k++) begin
                if (use_e[p] && slot_v[k] && slot_rw[k] && (slot_wa[k] == ra_e[p])) begin
                    if (!hit_seen && slot_ld[k] && (k < LD_AVAIL))
                        late_match = 1'b1;
                    if (!sel_done && (!slot_ld[k] || (k >= LD_AVAIL))) begin
                        fwd_sel[p*SW +: SW] = SW'(k);
                        sel_done            = 1'b1;
                    end
                    hit_seen = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_v  <= '0;
            slot_rw <= '0;
            slot_ld <= '0;
            use_e   <= '0;
            for (int k = 0; k < STAGES; k++) slot_wa[k] <= '0;
            for (int p = 0; p < NRD; p++)    ra_e[p]    <= '0;
        end else if (!mem_wait) begin
            slot_v  <= {slot_v[STAGES-2:0],  issue_ok};
            slot_rw <= {slot_rw[STAGES-2:0], issue_rw};
            slot_ld <= {slot_ld[STAGES-2:0], issue_ld};
            for (int k = STAGES - 1; k >= 1; k--) slot_wa[k] <= slot_wa[k-1];
            slot_wa[0] <= issue_wa;
            for (int p = 0; p < NRD; p++) ra_e[p] <= ra_d[p*AW +: AW];
            // Bubbles must not forward, otherwise a held consumer would match early.
            use_e <= ra_use & {NRD{issue_ok}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != {CNTW{1'b1}}))
            stall_cnt <= stall_cnt + CNTW'(1);
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!late_match)
                else $error("hazard_scoreboard: E consumer matched a producer not yet forwardable");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_scoreboard
//  Brief    : Directed bench for hazard_scoreboard (default build plus CNTW=2).
//  Revision : 1.0
// ============================================================================
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid, issue_rw, issue_ld;
    logic [3:0]  issue_wa;
    logic [7:0]  ra_d;
    logic [1:0]  ra_use;
    logic        flush, mem_wait;
    logic        stall, flush_d, bubble_e;
    logic [3:0]  fwd_sel;
    logic [15:0] stall_cnt;
    logic        stall_c2, flush_d_c2, bubble_e_c2;
    logic [3:0]  fwd_sel_c2;
    logic [1:0]  stall_cnt_c2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rw(issue_rw),
        .issue_ld(issue_ld), .issue_wa(issue_wa), .ra_d(ra_d), .ra_use(ra_use),
        .flush(flush), .mem_wait(mem_wait), .stall(stall), .flush_d(flush_d),
        .bubble_e(bubble_e), .fwd_sel(fwd_sel), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.CNTW(2)) dut_c2 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rw(issue_rw),
        .issue_ld(issue_ld), .issue_wa(issue_wa), .ra_d(ra_d), .ra_use(ra_use),
        .flush(flush), .mem_wait(mem_wait), .stall(stall_c2), .flush_d(flush_d_c2),
        .bubble_e(bubble_e_c2), .fwd_sel(fwd_sel_c2), .stall_cnt(stall_cnt_c2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic ld, input logic [3:0] wa,
                         input logic [3:0] ra0, input logic [3:0] ra1, input logic [1:0] use_p);
        issue_valid = v;
        issue_rw    = rw;
        issue_ld    = ld;
        issue_wa    = wa;
        ra_d        = {ra1, ra0};
        ra_use      = use_p;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 2'b00);
    endtask

    task automatic drain();
        idle();
        repeat (3) step();
    endtask

    initial begin
        idle();
        flush    = 1'b0;
        mem_wait = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall",    32'(stall),     0);
        check("rst_flush_d",  32'(flush_d),   0);
        check("rst_bubble",   32'(bubble_e),  0);
        check("rst_fwd",      32'(fwd_sel),   0);
        check("rst_cnt",      32'(stall_cnt), 0);
        check("rst_c2_fwd",   32'({stall_c2, flush_d_c2, bubble_e_c2, fwd_sel_c2}), 0);
        rst = 1'b1;

        // ALU chain: R1=R2+R3 ; R4=R1+R1
        drive(1, 1, 0, 4'd1, 4'd2, 4'd3, 2'b11); #1;
        check("alu_first_stall", 32'(stall), 0);
        step();
        drive(1, 1, 0, 4'd4, 4'd1, 4'd1, 2'b11); #1;
        check("alu_dep_stall", 32'(stall), 0);
        step();
        idle(); #1;
        check("alu_fwd", 32'(fwd_sel), 32'h5);
        drain();

        // Load-use: LDR R5,[R8] ; ADD R6=R5+R7
        drive(1, 1, 1, 4'd5, 4'd8, 4'd0, 2'b01); #1;
        check("ld_issue_stall", 32'(stall), 0);
        step();
        drive(1, 1, 0, 4'd6, 4'd5, 4'd7, 2'b11); #1;
        check("lu_stall",   32'(stall),    1);
        check("lu_bubble",  32'(bubble_e), 1);
        check("lu_flush_d", 32'(flush_d),  0);
        step();
        #1;
        check("lu_release",     32'(stall),        0);
        check("lu_rel_bubble",  32'(bubble_e),     0);
        check("lu_slot0_empty", 32'(dut.slot_v[0]), 0);
        step();
        idle(); #1;
        check("lu_fwd", 32'(fwd_sel),   32'h2);
        check("lu_cnt", 32'(stall_cnt), 1);
        drain();

        // Priority: two writers of R1, E reads R1 and R2
        drive(1, 1, 0, 4'd1, 4'd0, 4'd0, 2'b00); step();
        drive(1, 1, 0, 4'd1, 4'd0, 4'd0, 2'b00); step();
        drive(1, 1, 0, 4'd9, 4'd1, 4'd2, 2'b11); #1;
        check("prio_stall", 32'(stall), 0);
        step();
        idle(); #1;
        check("prio_fwd", 32'(fwd_sel), 32'h1);
        drain();

        // Flush during load-use stall
        drive(1, 1, 1, 4'd5, 4'd8, 4'd0, 2'b01); step();
        drive(1, 1, 0, 4'd6, 4'd5, 4'd7, 2'b11);
        flush = 1'b1; #1;
        check("fl_flush_d", 32'(flush_d),  1);
        check("fl_stall",   32'(stall),    0);
        check("fl_bubble",  32'(bubble_e), 1);
        step();
        flush = 1'b0;
        idle(); #1;
        check("fl_slot0_v", 32'(dut.slot_v[0]), 0);
        check("fl_fwd",     32'(fwd_sel),       0);
        check("fl_cnt",     32'(stall_cnt),     1);
        drain();

        // mem_wait freeze with a load in slot1
        drive(1, 1, 0, 4'd2, 4'd0, 4'd0, 2'b00); step();
        drive(1, 1, 1, 4'd5, 4'd2, 4'd0, 2'b01); #1;
        check("mw_ld_stall", 32'(stall), 0);
        step();
        drive(1, 1, 0, 4'd10, 4'd2, 4'd0, 2'b11); #1;
        check("mw_x_stall", 32'(stall), 0);
        step();
        idle();
        mem_wait = 1'b1;
        for (int c = 0; c < 3; c++) begin
            flush = (c == 1);
            #1;
            check("mw_stall",   32'(stall),    1);
            check("mw_bubble",  32'(bubble_e), 0);
            check("mw_flush_d", 32'(flush_d),  0);
            check("mw_fwd",     32'(fwd_sel),  32'h2);
            step();
        end
        flush    = 1'b0;
        mem_wait = 1'b0; #1;
        check("mw_after_stall", 32'(stall),        0);
        check("mw_after_fwd",   32'(fwd_sel),      32'h2);
        check("mw_slots_v",     32'(dut.slot_v),   32'h7);
        check("mw_slots_ld",    32'(dut.slot_ld),  32'h2);
        check("mw_cnt",         32'(stall_cnt),    4);
        check("c2_saturate",    32'(stall_cnt_c2), 3);
        drain();

        // One more load-use stall: main counter 5, narrow counter held at 3
        drive(1, 1, 1, 4'd5, 4'd8, 4'd0, 2'b01); step();
        drive(1, 1, 0, 4'd6, 4'd5, 4'd7, 2'b11); #1;
        check("lu2_stall", 32'(stall), 1);
        step(); step();
        idle(); #1;
        check("lu2_cnt",    32'(stall_cnt),    5);
        check("c2_hold",    32'(stall_cnt_c2), 3);
        drain();

        // Async reset with every slot occupied and a stall pending
        drive(1, 1, 0, 4'd1, 4'd0, 4'd0, 2'b00); step();
        drive(1, 1, 0, 4'd2, 4'd0, 4'd0, 2'b00); step();
        drive(1, 1, 1, 4'd5, 4'd1, 4'd0, 2'b01); #1;
        check("ar_ld_stall", 32'(stall), 0);
        step();
        drive(1, 1, 0, 4'd6, 4'd5, 4'd7, 2'b11); #1;
        check("ar_pre_v",     32'(dut.slot_v), 32'h7);
        check("ar_pre_stall", 32'(stall),      1);
        check("ar_pre_fwd",   32'(fwd_sel),    32'h2);
        #1;
        rst = 1'b0;
        #1;
        check("ar_v",      32'(dut.slot_v), 0);
        check("ar_stall",  32'(stall),      0);
        check("ar_bubble", 32'(bubble_e),   0);
        check("ar_fwd",    32'(fwd_sel),    0);
        check("ar_cnt",    32'(stall_cnt),  0);
        check("ar_c2_cnt", 32'(stall_cnt_c2), 0);
        idle();
        step();
        rst = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
